// File: rtl/free_list_bank_if.sv
// Rename-stage free-list bank bus: push (reclaim) side, pop (rename) side and status.
interface free_list_bank_if #(
  parameter int unsigned PR_COUNT   = 128,
  parameter int unsigned BANK_COUNT = 4
);
  localparam int unsigned LOG_PR_COUNT = $clog2(PR_COUNT);
  localparam int unsigned LENGTH       = PR_COUNT / BANK_COUNT;
  localparam int unsigned PTR_W        = $clog2(LENGTH) + 1;

  logic                    enq_valid;
  logic [LOG_PR_COUNT-1:0] enq_PR_tag;
  logic                    deq_valid;
  logic [LOG_PR_COUNT-1:0] deq_PR_tag;
  logic                    deq_ready;
  logic [PTR_W-1:0]        count;
  logic                    below_lower;
  logic                    above_upper;
  logic                    err_overflow;
  logic                    err_bank;

  modport master (
    output enq_valid, enq_PR_tag, deq_ready,
    input  deq_valid, deq_PR_tag, count, below_lower, above_upper, err_overflow, err_bank
  );

  modport slave (
    input  enq_valid, enq_PR_tag, deq_ready,
    output deq_valid, deq_PR_tag, count, below_lower, above_upper, err_overflow, err_bank
  );
endinterface

// File: rtl/free_list_bank.sv
// One bank of the PRF free list: circular FIFO of free PR tags with watermarks and sticky errors.
// Optional same-cycle empty-bank bypass enabled by defining FREE_LIST_BANK_BYPASS_EN.
module free_list_bank #(
  parameter int unsigned PR_COUNT        = 128,
  parameter int unsigned AR_COUNT        = 32,
  parameter int unsigned BANK_COUNT      = 4,
  parameter int unsigned BANK_INDEX      = 0,
  parameter int unsigned LENGTH          = PR_COUNT / BANK_COUNT,
  parameter int unsigned LOWER_THRESHOLD = 8,
  parameter int unsigned UPPER_THRESHOLD = 24
) (
  input  logic CLK,
  input  logic nRST,
  free_list_bank_if.slave bus
);
  localparam int unsigned LOG_PR_COUNT   = $clog2(PR_COUNT);
  localparam int unsigned LOG_BANK_COUNT = $clog2(BANK_COUNT);
  localparam int unsigned PTR_W          = $clog2(LENGTH) + 1;
  localparam int unsigned IDX_W          = PTR_W - 1;
  localparam int unsigned RESET_COUNT    = (PR_COUNT - AR_COUNT) / BANK_COUNT;
  // Smallest PR owned by this bank that is not architecturally mapped at reset
  localparam int unsigned FIRST_PR =
    ((AR_COUNT + BANK_COUNT - 1 - BANK_INDEX) / BANK_COUNT) * BANK_COUNT + BANK_INDEX;

  logic [LOG_PR_COUNT-1:0] r_mem [LENGTH];
  logic [PTR_W-1:0]        r_head;
  logic [PTR_W-1:0]        r_tail;
  logic [PTR_W-1:0]        r_count;
  logic                    r_err_overflow;
  logic                    r_err_bank;

  logic             w_empty;
  logic             w_full;
  logic             w_full_post;
  logic             w_tag_ok;
  logic             w_pop;
  logic             w_push;
  logic             w_byp_avail;
  logic             w_bypass;
  logic [IDX_W-1:0] w_head_idx;
  logic [IDX_W-1:0] w_tail_idx;

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
  assign w_tag_ok   = (bus.enq_PR_tag[LOG_BANK_COUNT-1:0] == LOG_BANK_COUNT'(BANK_INDEX));

`ifdef FREE_LIST_BANK_BYPASS_EN
  // Empty bank forwards a legal incoming tag straight to the rename port
  assign w_byp_avail = w_empty && bus.enq_valid && w_tag_ok;
  assign w_bypass    = w_byp_avail && bus.deq_ready;
`else
  assign w_byp_avail = 1'b0;
  assign w_bypass    = 1'b0;
`endif

  assign w_pop       = !w_empty && bus.deq_ready;
  // A pop in the same cycle frees a slot for the push
  assign w_full_post = w_full && !w_pop;
  assign w_push      = bus.enq_valid && w_tag_ok && !w_full_post && !w_bypass;

  assign bus.deq_valid    = !w_empty || w_byp_avail;
  assign bus.deq_PR_tag   = w_byp_avail ? bus.enq_PR_tag : r_mem[w_head_idx];
  assign bus.count        = r_count;
  assign bus.below_lower  = (32'(r_count) < LOWER_THRESHOLD);
  assign bus.above_upper  = (32'(r_count) > UPPER_THRESHOLD);
  assign bus.err_overflow = r_err_overflow;
  assign bus.err_bank     = r_err_bank;

  // Tag storage; reset image is the bank's unmapped PRs in ascending order
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(LENGTH); i++) begin
        r_mem[i] <= (i < int'(RESET_COUNT)) ?
                    LOG_PR_COUNT'(FIRST_PR + 32'(i) * BANK_COUNT) : '0;
      end
    end else if (w_push) begin
      r_mem[w_tail_idx] <= bus.enq_PR_tag;
    end
  end

  // Pointers, occupancy and sticky error flags
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head         <= '0;
      r_tail         <= PTR_W'(RESET_COUNT);
      r_count        <= PTR_W'(RESET_COUNT);
      r_err_overflow <= 1'b0;
      r_err_bank     <= 1'b0;
    end else begin
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + PTR_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - PTR_W'(1);
      end
      if (bus.enq_valid && w_full_post) begin
        r_err_overflow <= 1'b1;
      end
      if (bus.enq_valid && !w_tag_ok) begin
        r_err_bank <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_free_list_bank.sv
// Directed bench for free_list_bank: bank 0 full scenario plus bank 3 reset image.
module tb_free_list_bank;
  logic CLK = 1'b0;
  logic nRST;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;

  free_list_bank_if #(.PR_COUNT(128), .BANK_COUNT(4)) b0 ();
  free_list_bank_if #(.PR_COUNT(128), .BANK_COUNT(4)) b3 ();

  free_list_bank #(.BANK_INDEX(0)) u_dut0 (.CLK(CLK), .nRST(nRST), .bus(b0.slave));
  free_list_bank #(.BANK_INDEX(3)) u_dut3 (.CLK(CLK), .nRST(nRST), .bus(b3.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    b0.enq_valid = 1'b0; b0.enq_PR_tag = '0; b0.deq_ready = 1'b0;
    b3.enq_valid = 1'b0; b3.enq_PR_tag = '0; b3.deq_ready = 1'b0;
    #12;
    chk("rst_valid",  32'(b0.deq_valid), 1);
    chk("rst_tag",    32'(b0.deq_PR_tag), 32);
    chk("rst_count",  32'(b0.count), 24);
    chk("rst_below",  32'(b0.below_lower), 0);
    chk("rst_above",  32'(b0.above_upper), 0);
    chk("rst_errov",  32'(b0.err_overflow), 0);
    chk("rst_errbk",  32'(b0.err_bank), 0);
    chk("rst3_tag",   32'(b3.deq_PR_tag), 35);
    chk("rst3_count", 32'(b3.count), 24);
    nRST = 1'b1;

    // Drain both banks
    b0.deq_ready = 1'b1;
    b3.deq_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      chk("drain_valid", 32'(b0.deq_valid), 1);
      chk("drain_tag",   32'(b0.deq_PR_tag), 32'(32 + 4 * i));
      chk("drain3_tag",  32'(b3.deq_PR_tag), 32'(35 + 4 * i));
      tick();
    end
    chk("empty_count", 32'(b0.count), 0);
    chk("empty_valid", 32'(b0.deq_valid), 0);
    chk("empty_below", 32'(b0.below_lower), 1);
    chk("empty3_valid", 32'(b3.deq_valid), 0);
    tick();
    chk("ready_empty_count", 32'(b0.count), 0);
    chk("ready_empty_valid", 32'(b0.deq_valid), 0);
    b0.deq_ready = 1'b0;
    b3.deq_ready = 1'b0;

    // Wrong-bank push
    b0.enq_valid = 1'b1; b0.enq_PR_tag = 7'd33;
    tick();
    b0.enq_valid = 1'b0;
    chk("bank_err",    32'(b0.err_bank), 1);
    chk("bank_count",  32'(b0.count), 0);
    chk("bank_valid",  32'(b0.deq_valid), 0);
    chk("bank_errov",  32'(b0.err_overflow), 0);

    b0.enq_valid = 1'b1; b0.enq_PR_tag = 7'd40;
`ifdef FREE_LIST_BANK_BYPASS_EN
    b0.deq_ready = 1'b1;
    chk("byp_valid", 32'(b0.deq_valid), 1);
    chk("byp_tag",   32'(b0.deq_PR_tag), 40);
    tick();
    b0.enq_valid = 1'b0; b0.deq_ready = 1'b0;
    chk("byp_count", 32'(b0.count), 0);
    chk("byp_after_valid", 32'(b0.deq_valid), 0);
`else
    chk("nobyp_valid", 32'(b0.deq_valid), 0);
    tick();
    b0.enq_valid = 1'b0;
    chk("push40_valid", 32'(b0.deq_valid), 1);
    chk("push40_tag",   32'(b0.deq_PR_tag), 40);
    chk("push40_count", 32'(b0.count), 1);
    b0.deq_ready = 1'b1;
    tick();
    b0.deq_ready = 1'b0;
    chk("pop40_count", 32'(b0.count), 0);
    chk("pop40_valid", 32'(b0.deq_valid), 0);
`endif

    // Asynchronous reset between edges with a push pending
    b0.enq_valid = 1'b1; b0.enq_PR_tag = 7'd0;
    #2 nRST = 1'b0;
    #1;
    chk("arst_count",  32'(b0.count), 24);
    chk("arst_valid",  32'(b0.deq_valid), 1);
    chk("arst_tag",    32'(b0.deq_PR_tag), 32);
    chk("arst_errbk",  32'(b0.err_bank), 0);
    chk("arst3_tag",   32'(b3.deq_PR_tag), 35);
    chk("arst3_count", 32'(b3.count), 24);
    b0.enq_valid = 1'b0;
    #2 nRST = 1'b1;
    tick();
    chk("arst_lost_push", 32'(b0.count), 24);

    // Fill to full
    for (int k = 0; k < 8; k++) begin
      b0.enq_valid = 1'b1; b0.enq_PR_tag = 7'(4 * k);
      tick();
    end
    b0.enq_valid = 1'b0;
    chk("full_count", 32'(b0.count), 32);
    chk("full_above", 32'(b0.above_upper), 1);
    chk("full_tag",   32'(b0.deq_PR_tag), 32);
    chk("full_errov", 32'(b0.err_overflow), 0);

    // Full: simultaneous push and pop
    b0.enq_valid = 1'b1; b0.enq_PR_tag = 7'd0; b0.deq_ready = 1'b1;
    chk("pp_tag", 32'(b0.deq_PR_tag), 32);
    tick();
    b0.enq_valid = 1'b0; b0.deq_ready = 1'b0;
    chk("pp_count", 32'(b0.count), 32);
    chk("pp_errov", 32'(b0.err_overflow), 0);
    chk("pp_head",  32'(b0.deq_PR_tag), 36);

    // Overflow
    b0.enq_valid = 1'b1; b0.enq_PR_tag = 7'd8;
    tick();
    b0.enq_valid = 1'b0;
    chk("ovf_err",   32'(b0.err_overflow), 1);
    chk("ovf_count", 32'(b0.count), 32);
    chk("ovf_errbk", 32'(b0.err_bank), 0);
    chk("ovf_head",  32'(b0.deq_PR_tag), 36);

    // Pop 30: 36..124 then 0..24
    b0.deq_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      chk("pop30_tag", 32'(b0.deq_PR_tag), (i < 23) ? 32'(36 + 4 * i) : 32'(4 * (i - 23)));
      tick();
    end
    b0.deq_ready = 1'b0;
    chk("pop30_count", 32'(b0.count), 2);
    chk("pop30_below", 32'(b0.below_lower), 1);
    chk("pop30_tag_next", 32'(b0.deq_PR_tag), 28);

    // Push 30 across the index wrap
    for (int k = 0; k < 30; k++) begin
      b0.enq_valid = 1'b1; b0.enq_PR_tag = 7'(4 * (k + 1));
      tick();
    end
    b0.enq_valid = 1'b0;
    chk("wrap_count", 32'(b0.count), 32);
    chk("wrap_above", 32'(b0.above_upper), 1);

    // Drain 32 in FIFO order: 28, 0, 4..120
    b0.deq_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("wrap_valid", 32'(b0.deq_valid), 1);
      chk("wrap_tag", 32'(b0.deq_PR_tag), (i == 0) ? 32'd28 : 32'(4 * (i - 1)));
      tick();
    end
    b0.deq_ready = 1'b0;
    chk("wrap_empty_valid", 32'(b0.deq_valid), 0);
    chk("wrap_empty_count", 32'(b0.count), 0);
    chk("wrap_empty_below", 32'(b0.below_lower), 1);
    chk("sticky_errov",     32'(b0.err_overflow), 1);

    // Final asynchronous reset clears sticky overflow
    #2 nRST = 1'b0;
    #1;
    chk("arst2_errov", 32'(b0.err_overflow), 0);
    chk("arst2_count", 32'(b0.count), 24);
    chk("arst2_tag",   32'(b0.deq_PR_tag), 32);
    #2 nRST = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/free_list_bank.md
Name: free_list_bank

Overview:
- One bank of the physical-register free list in the rename stage; four instances (one per PRF bank) form the full free list.
- Circular FIFO of free PR tags: rename pops one tag per cycle, commit/reclaim pushes one tag per cycle.
- Parametrised in PR count, bank count and thresholds, with watermark outputs for rename throttling.
- Adds bank-ownership checking and sticky error reporting.

Parameters:
- PR_COUNT, 128: total physical registers.
- AR_COUNT, 32: architectural registers; PR 0..AR_COUNT-1 are mapped at reset, so they are never free at reset.
- BANK_COUNT, 4: number of free-list banks. Must be a power of 2.
- BANK_INDEX, 0: this bank's index, 0..BANK_COUNT-1.
- LENGTH, PR_COUNT/BANK_COUNT: entries in this bank.
- LOWER_THRESHOLD, 8: low-watermark count.
- UPPER_THRESHOLD, 24: high-watermark count.
- Derived: LOG_PR_COUNT = $clog2(PR_COUNT); LOG_BANK_COUNT = $clog2(BANK_COUNT); PTR_W = $clog2(LENGTH)+1 (MSB is the wrap bit).

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- enq_valid  in  1  push request (reclaimed PR)
- enq_PR_tag  in  LOG_PR_COUNT  tag to push
- deq_valid  out  1  head entry available
- deq_PR_tag  out  LOG_PR_COUNT  head tag
- deq_ready  in  1  rename consumes the head this cycle
- count  out  PTR_W  entries currently held
- below_lower  out  1  count < LOWER_THRESHOLD
- above_upper  out  1  count > UPPER_THRESHOLD
- err_overflow  out  1  sticky: push attempted while full
- err_bank  out  1  sticky: pushed tag not owned by this bank

Behaviour:
- Clocking and reset: one clock CLK. Reset nRST is asynchronous, active-low. All state is flopped on posedge CLK or negedge nRST.
- Reset contents: the array holds, in ascending order, every PR p with p % BANK_COUNT == BANK_INDEX and p >= AR_COUNT.
  - Reset count RC = (PR_COUNT-AR_COUNT)/BANK_COUNT (24 with defaults).
  - Bank 0 slots 0..23 = 32, 36, ..., 124.
  - head = 0, tail = RC. Entries beyond RC are don't-care.
- Output reset values:
  - count = RC; deq_valid = (RC != 0); deq_PR_tag = first reset entry.
  - err_overflow = 0; err_bank = 0.
  - below_lower and above_upper = threshold compare of RC (both 0 with defaults).
- Pointers: head and tail are PTR_W bits. Index = low bits; wrap at LENGTH (LENGTH is a power of 2).
  - Empty when head == tail.
  - Full when indices are equal and wrap bits differ.
- Dequeue:
  - deq_valid = !empty, derived combinationally from registered state.
  - deq_PR_tag = array[head index], combinational read.
  - A pop occurs when deq_valid && deq_ready; head advances by 1 at the clock edge.
  - deq_ready while empty is ignored; no state change.
- Enqueue:
  - Accepted when enq_valid && !full && enq_PR_tag[LOG_BANK_COUNT-1:0] == BANK_INDEX.
  - On accept: write array[tail index], tail +1.
  - If full: tag dropped, err_overflow set.
  - If low bits mismatch: tag dropped, err_bank set.
  - Both conditions may set both flags. Flags clear only on reset.
  - A pushed entry becomes visible at the head no earlier than the next cycle (no bypass unless the optional feature is enabled).
- Simultaneous push and pop:
  - Both occur; count is unchanged.
  - When full, the pop frees a slot combinationally, so a simultaneous valid push is still accepted and no overflow is flagged. The full check uses post-pop state.
- count is a register: count_next = count + push - pop.
- Thresholds: combinational compares on registered count.
- Reset mid-operation: all state returns immediately to the reset image; in-flight push/pop in that cycle is lost.

Optional Feature:
- Macro: FREE_LIST_BANK_BYPASS_EN.
- Defined, empty bank: if enq_valid with a legal tag, then deq_valid = 1 and deq_PR_tag = enq_PR_tag in the same cycle.
  - If deq_ready is also high, the tag bypasses: pointers and count are unchanged and nothing is written.
  - If deq_ready is low, a normal push occurs.
- Undefined: an empty bank never asserts deq_valid combinationally from enq inputs (one-cycle push-to-pop latency).

Test Plan:
- Reset, bank 0 defaults: deq_valid=1, deq_PR_tag=32, count=24, below_lower=0, above_upper=0. Pop 24 times with deq_ready=1: tags 32, 36, ..., 124, then deq_valid=0, count=0, below_lower=1.
- From empty, push 33 (bank 0): err_bank=1, count stays 0. Push 40: next cycle deq_valid=1, deq_PR_tag=40. With bypass enabled instead: in the push cycle, deq_ready=1 consumes 40 and count stays 0.
- From reset, push 8 legal tags (0, 4, ..., 28): count=32 (full), above_upper=1. Push one more: err_overflow=1, count=32.
- Full bank, simultaneous push of 0 and pop: push accepted, count=32, err_overflow=0. The popped tag is 32; the pushed tag appears after the wrap, at slot index 0.
- Wrap: pop 30, push 30 legal tags, then pop all 32 and check exact FIFO order across the index wrap; wrap bit toggles, no spurious full/empty.
- Assert nRST mid-stream (asynchronously, between edges): outputs return to reset values immediately; sticky errors clear. Repeat with BANK_INDEX=3: first tag 35, last 127.
